// File: rtl/fpu_ftoi.sv
// fpu_ftoi: multi-cycle PinKY float (1/8/7, implied leading 1) to 16-bit two's-complement
// integer converter. Truncates toward zero and saturates on overflow, Inf and NaN.
// Fixed latency: a start accepted at edge N gives done during cycle N+3.
module fpu_ftoi #(
    parameter int WIDTH     = 16,
    parameter int EXP_BITS  = 8,
    parameter int MANT_BITS = 7,
    parameter int BIAS      = 127
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam int EW = EXP_BITS + 1;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_UNPACK = 2'd1;
    localparam logic [1:0] S_SHIFT  = 2'd2;
    localparam logic [1:0] S_PACK   = 2'd3;

    localparam logic [WIDTH-1:0] SAT_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]           r_state;
    logic                 r_sign;
    logic [EXP_BITS-1:0]  r_exp;
    logic [MANT_BITS:0]   r_mant;
    logic [EW-1:0]        r_e;
    logic                 r_zero;
    logic                 r_sat;
    logic                 r_ovf_flag;
    logic [WIDTH-1:0]     r_mag;

    logic [EW-1:0]        w_e;
    logic                 w_neg;
    logic                 w_big;
    logic                 w_exact_min;
    logic                 w_exp_max;
    logic [WIDTH-1:0]     w_mant_ext;
    logic [WIDTH-1:0]     w_mag;

    // Unbiased exponent and range classification, used on the UNPACK edge
    always_comb begin
        w_e         = {1'b0, r_exp} - EW'(BIAS);
        w_neg       = w_e[EW-1];
        w_exp_max   = (r_exp == '1);
        w_big       = !w_neg && (w_e >= EW'(WIDTH-1));
        // -2^(WIDTH-1) is representable: takes the saturation path but is not an overflow
        w_exact_min = r_sign && (w_e == EW'(WIDTH-1)) && (r_mant[MANT_BITS-1:0] == '0);
    end

    // Align the significand to the binary point; bits shifted out are truncated
    always_comb begin
        w_mant_ext = WIDTH'(r_mant);
        if (r_e >= EW'(MANT_BITS)) begin
            w_mag = w_mant_ext << (r_e - EW'(MANT_BITS));
        end else begin
            w_mag = w_mant_ext >> (EW'(MANT_BITS) - r_e);
        end
    end

    // Conversion FSM and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_sign     <= 1'b0;
            r_exp      <= '0;
            r_mant     <= '0;
            r_e        <= '0;
            r_zero     <= 1'b0;
            r_sat      <= 1'b0;
            r_ovf_flag <= 1'b0;
            r_mag      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            ovf        <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_sign  <= op[WIDTH-1];
                        r_exp   <= op[WIDTH-2 -: EXP_BITS];
                        r_mant  <= {1'b1, op[MANT_BITS-1:0]};
                        busy    <= 1'b1;
                        r_state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    r_e        <= w_e;
                    r_zero     <= (r_exp == '0) || w_neg;
                    r_sat      <= w_exp_max || w_big;
                    r_ovf_flag <= w_exp_max || (w_big && !w_exact_min);
                    r_state    <= S_SHIFT;
                end
                S_SHIFT: begin
                    r_mag   <= (r_zero || r_sat) ? '0 : w_mag;
                    r_state <= S_PACK;
                end
                default: begin
                    if (r_sat) begin
                        result <= r_sign ? SAT_NEG : SAT_POS;
                    end else begin
                        // Negating a zero magnitude yields zero, so no negative zero
                        result <= r_sign ? (~r_mag + 1'b1) : r_mag;
                    end
                    ovf     <= r_ovf_flag;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpu_ftoi.sv
// Directed bench for fpu_ftoi: vector table plus hand-written handshake/reset sequences.
module tb_fpu_ftoi;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] op;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        ovf;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    typedef struct {
        logic [15:0] op;
        logic [15:0] res;
        logic        ovf;
    } vec_t;

    vec_t vecs[17];

    fpu_ftoi #(
        .WIDTH(16),
        .EXP_BITS(8),
        .MANT_BITS(7),
        .BIAS(127)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .busy(busy),
        .done(done),
        .result(result),
        .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    // Counts rising edges until done is seen (sampled 1 time unit after each edge); -1 on timeout
    task automatic wait_done(output int cyc);
        int  i;
        bit  seen;
        cyc  = -1;
        seen = 1'b0;
        i    = 0;
        while (!seen && i < 8) begin
            @(posedge clk);
            #1;
            i++;
            if (done) begin
                seen = 1'b1;
                cyc  = i;
            end
        end
    endtask

    // Single-cycle start pulse, op scrambled after acceptance; returns latency in cycles
    task automatic run_conv(input logic [15:0] a, output int cyc);
        @(negedge clk);
        op    = a;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        op    = ~a;
        chk("busy after accept", {15'd0, busy}, 16'd1);
        wait_done(cyc);
    endtask

    initial begin
        int cyc;

        vecs = '{
            '{16'h3F80, 16'h0001, 1'b0},  // 1.0
            '{16'hC140, 16'hFFF4, 1'b0},  // -12.0
            '{16'h4030, 16'h0002, 1'b0},  // 2.75 truncates
            '{16'h3F00, 16'h0000, 1'b0},  // 0.5
            '{16'hBF00, 16'h0000, 1'b0},  // -0.5, no negative zero
            '{16'h0000, 16'h0000, 1'b0},  // zero
            '{16'h0055, 16'h0000, 1'b0},  // denormal flush
            '{16'h4700, 16'h7FFF, 1'b1},  // 32768.0 saturates
            '{16'hC700, 16'h8000, 1'b0},  // -32768.0 exact
            '{16'hC701, 16'h8000, 1'b1},  // just below -32768 saturates
            '{16'h7F80, 16'h7FFF, 1'b1},  // +Inf
            '{16'hFF80, 16'h8000, 1'b1},  // -Inf
            '{16'h7F00, 16'h7FFF, 1'b1},  // huge finite
            '{16'h46FF, 16'h7F80, 1'b0},  // largest e=14 value
            '{16'hC6FF, 16'h8080, 1'b0},  // its negative
            '{16'hBF80, 16'hFFFF, 1'b0},  // -1.0
            '{16'h42C8, 16'h0064, 1'b0}   // 100.0
        };

        reset = 1'b0;
        start = 1'b0;
        op    = 16'h0000;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy",   {15'd0, busy}, 16'd0);
        chk("reset done",   {15'd0, done}, 16'd0);
        chk("reset result", result,        16'h0000);
        chk("reset ovf",    {15'd0, ovf},  16'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 17; i++) begin
            run_conv(vecs[i].op, cyc);
            chk($sformatf("vec%0d latency", i), 16'(cyc), 16'd3);
            chk($sformatf("vec%0d result", i), result, vecs[i].res);
            chk($sformatf("vec%0d ovf", i), {15'd0, ovf}, {15'd0, vecs[i].ovf});
            chk($sformatf("vec%0d busy at done", i), {15'd0, busy}, 16'd0);
        end

        // start held high through UNPACK and SHIFT with a different op: ignored
        @(negedge clk);
        op    = 16'hC140;
        start = 1'b1;
        @(posedge clk);
        #1;
        op = 16'h4700;
        @(posedge clk);
        #1;
        chk("ignore: done early", {15'd0, done}, 16'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(cyc);
        chk("ignore: latency", 16'(cyc), 16'd1);
        chk("ignore: result", result, 16'hFFF4);
        chk("ignore: ovf", {15'd0, ovf}, 16'd0);
        @(posedge clk);
        #1;
        chk("ignore: done pulse width", {15'd0, done}, 16'd0);
        chk("ignore: no queued op", {15'd0, busy}, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("ignore: no late done", {15'd0, done}, 16'd0);

        // start in the done cycle is accepted; result held until the next done
        run_conv(16'h4030, cyc);
        chk("b2b: first latency", 16'(cyc), 16'd3);
        chk("b2b: first result", result, 16'h0002);
        op    = 16'hFF80;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b: done deasserts", {15'd0, done}, 16'd0);
        chk("b2b: busy", {15'd0, busy}, 16'd1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("b2b: result held", result, 16'h0002);
        chk("b2b: ovf held", {15'd0, ovf}, 16'd0);
        @(posedge clk);
        #1;
        chk("b2b: second done", {15'd0, done}, 16'd1);
        chk("b2b: second result", result, 16'h8000);
        chk("b2b: second ovf", {15'd0, ovf}, 16'd1);

        // Reset during SHIFT clears everything and produces no done
        run_conv(16'h4700, cyc);
        chk("pre-reset result", result, 16'h7FFF);
        @(negedge clk);
        op    = 16'h3F80;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("abort busy",   {15'd0, busy}, 16'd0);
        chk("abort done",   {15'd0, done}, 16'd0);
        chk("abort result", result,        16'h0000);
        chk("abort ovf",    {15'd0, ovf},  16'd0);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("abort no done %0d", k), {15'd0, done}, 16'd0);
        end
        run_conv(16'hBF80, cyc);
        chk("post-reset latency", 16'(cyc), 16'd3);
        chk("post-reset result", result, 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
